unidade_controle_jogo: RTL

Control-unit FSM for the memory-sequence game top level (circuito_jogo_base). It sequences the datapath:
- zeros and advances the round counter and play-address counter;
- registers button plays and evaluates the compare result;
- owns the per-play inactivity timeout counter;
- raises the terminal ganhou/perdeu/pronto flags.

The datapath (counters, ROM, comparator, edge detector) stays outside. This block only issues control strobes.

---
 rtl/unidade_controle_jogo_pkg.sv | 60 ++++++
 rtl/unidade_controle_jogo_if.sv | 33 +++
 rtl/unidade_controle_jogo_contador_timeout.sv | 40 ++++
 rtl/unidade_controle_jogo.sv | 96 +++++++++
 4 files changed

// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes (also shown
// on the debug 7-segment display), timeout defaults and the Moore output decode.
package unidade_controle_jogo_pkg;

    localparam logic [3:0] ST_INICIAL        = 4'h0;
    localparam logic [3:0] ST_PREPARACAO     = 4'h1;
    localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
    localparam logic [3:0] ST_ESPERA_JOGADA  = 4'h3;
    localparam logic [3:0] ST_REGISTRA       = 4'h4;
    localparam logic [3:0] ST_COMPARA        = 4'h5;
    localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h6;
    localparam logic [3:0] ST_PROXIMA_RODADA = 4'h7;
    localparam logic [3:0] ST_FIM_ACERTO     = 4'hA;
    localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hD;
    localparam logic [3:0] ST_FIM_ERRO       = 4'hE;

    localparam int TIMEOUT_CICLOS_PADRAO = 5000;
    localparam int TIMEOUT_W_PADRAO      = 13;

    typedef struct packed {
        logic zeraE;
        logic contaE;
        logic zeraR;
        logic contaR;
        logic registraR;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } saidas_t;

    // Strobes and flags asserted while sitting in a given state; unused codes give all zeros.
    function automatic saidas_t decodifica_saidas(input logic [3:0] estado);
        saidas_t s;
        s = '0;
        case (estado)
            ST_PREPARACAO:     begin s.zeraR = 1'b1; s.zeraE = 1'b1; end
            ST_INICIA_RODADA:  s.zeraE = 1'b1;
            ST_REGISTRA:       s.registraR = 1'b1;
            ST_PROXIMA_JOGADA: s.contaE = 1'b1;
            ST_PROXIMA_RODADA: s.contaR = 1'b1;
            ST_FIM_ACERTO:     begin s.pronto = 1'b1; s.ganhou = 1'b1; end
            ST_FIM_ERRO:       begin s.pronto = 1'b1; s.perdeu = 1'b1; end
            ST_FIM_TIMEOUT:    begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
            default:           s = '0;
        endcase
        return s;
    endfunction

    // Codes that correspond to a real state; anything else reads back as inicial.
    function automatic logic estado_valido(input logic [3:0] estado);
        case (estado)
            ST_INICIAL, ST_PREPARACAO, ST_INICIA_RODADA, ST_ESPERA_JOGADA,
            ST_REGISTRA, ST_COMPARA, ST_PROXIMA_JOGADA, ST_PROXIMA_RODADA,
            ST_FIM_ACERTO, ST_FIM_TIMEOUT, ST_FIM_ERRO: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game control unit (master) and the datapath (slave).
interface unidade_controle_jogo_if;

    logic       jogar;
    logic       tem_jogada;
    logic       jogada_correta;
    logic       enderecoIgualRodada;
    logic       fimR;

    logic       zeraE;
    logic       contaE;
    logic       zeraR;
    logic       contaR;
    logic       registraR;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  jogar, tem_jogada, jogada_correta, enderecoIgualRodada, fimR,
        output zeraE, contaE, zeraR, contaR, registraR,
        output pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output jogar, tem_jogada, jogada_correta, enderecoIgualRodada, fimR,
        input  zeraE, contaE, zeraR, contaR, registraR,
        input  pronto, ganhou, perdeu, db_timeout, db_estado
    );

endinterface

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-play inactivity counter: cleared by zera_i, advanced by conta_i,
// fim_o flags the last allowed waiting cycle.
module unidade_controle_jogo_contador_timeout #(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TIMEOUT_W      = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_i,
    input  logic conta_i,
    output logic fim_o
);

    localparam logic [TIMEOUT_W-1:0] TC_FIM = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

    logic [TIMEOUT_W-1:0] tc_q;
    logic [TIMEOUT_W-1:0] tc_d;

    // Clear has priority; the FSM leaves the waiting state at TC_FIM so the count never wraps.
    always_comb begin
        tc_d = tc_q;
        if (zera_i) begin
            tc_d = '0;
        end else if (conta_i) begin
            tc_d = tc_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            tc_q <= '0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign fim_o = (tc_q == TC_FIM);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory-sequence game: Moore FSM issuing datapath strobes.
//
// state             | meaning
// 0x0 inicial       | idle, waiting for jogar
// 0x1 preparacao    | clear round and address counters
// 0x2 inicia_rodada | clear address counter at start of a round
// 0x3 espera_jogada | waiting for a button play, timeout running
// 0x4 registra      | load play register
// 0x5 compara       | evaluate compare result
// 0x6 proxima_jogada| advance play address
// 0x7 proxima_rodada| advance round counter
// 0xA fim_acerto    | game won
// 0xD fim_timeout   | game lost by inactivity
// 0xE fim_erro      | game lost by wrong play
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
    parameter int TIMEOUT_W      = TIMEOUT_W_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    unidade_controle_jogo_if.master ctl
);

    logic [3:0] estado_q;
    logic [3:0] estado_d;
    logic       tc_zera;
    logic       tc_conta;
    logic       tc_fim;
    saidas_t    saidas;

    unidade_controle_jogo_contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_contador_timeout (
        .clock   (clock),
        .reset   (reset),
        .zera_i  (tc_zera),
        .conta_i (tc_conta),
        .fim_o   (tc_fim)
    );

    // Every path into espera_jogada passes through a state that clears the counter.
    assign tc_zera  = (estado_q == ST_PREPARACAO) || (estado_q == ST_INICIA_RODADA)
                   || (estado_q == ST_PROXIMA_JOGADA);
    assign tc_conta = (estado_q == ST_ESPERA_JOGADA);

    // Next-state logic; a play wins over a simultaneous timeout.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL:        if (ctl.jogar) estado_d = ST_PREPARACAO;
            ST_PREPARACAO:     estado_d = ST_INICIA_RODADA;
            ST_INICIA_RODADA:  estado_d = ST_ESPERA_JOGADA;
            ST_ESPERA_JOGADA: begin
                if (ctl.tem_jogada)  estado_d = ST_REGISTRA;
                else if (tc_fim)     estado_d = ST_FIM_TIMEOUT;
            end
            ST_REGISTRA:       estado_d = ST_COMPARA;
            ST_COMPARA: begin
                if (!ctl.jogada_correta)                      estado_d = ST_FIM_ERRO;
                else if (ctl.enderecoIgualRodada && ctl.fimR) estado_d = ST_FIM_ACERTO;
                else if (ctl.enderecoIgualRodada)             estado_d = ST_PROXIMA_RODADA;
                else                                          estado_d = ST_PROXIMA_JOGADA;
            end
            ST_PROXIMA_JOGADA: estado_d = ST_ESPERA_JOGADA;
            ST_PROXIMA_RODADA: estado_d = ST_INICIA_RODADA;
            ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT:
                               if (ctl.jogar) estado_d = ST_PREPARACAO;
            default:           estado_d = ST_INICIAL;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign saidas         = decodifica_saidas(estado_q);
    assign ctl.zeraE      = saidas.zeraE;
    assign ctl.contaE     = saidas.contaE;
    assign ctl.zeraR      = saidas.zeraR;
    assign ctl.contaR     = saidas.contaR;
    assign ctl.registraR  = saidas.registraR;
    assign ctl.pronto     = saidas.pronto;
    assign ctl.ganhou     = saidas.ganhou;
    assign ctl.perdeu     = saidas.perdeu;
    assign ctl.db_timeout = saidas.db_timeout;
    assign ctl.db_estado  = estado_valido(estado_q) ? estado_q : ST_INICIAL;

endmodule
